// File: rtl/shift_deserializer.sv
// shift_deserializer: collects WIDTH/LANES serial beats of LANES bits into a
// WIDTH-bit word. Shift order is selected by MSB_FIRST. The finished word sits
// in its own output register so the next frame can fill behind it, and the
// serial side only stalls when a completing beat would overwrite an unconsumed
// word.
module shift_deserializer #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0,
    localparam int BEATS    = WIDTH / LANES,
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [LANES-1:0] s_in,
    output logic             s_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [CNT_W-1:0] beat_cnt
);

    // A partial last beat could never be assembled into a whole word.
    if ((LANES < 1) || (LANES > WIDTH) || (WIDTH % LANES != 0)) begin : g_bad_params
        $fatal(1, "shift_deserializer: WIDTH must be a positive multiple of LANES");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic             last_beat;
    logic             accept;
    logic             consume;

    // Shift the current contents by one beat and insert the new beat at the
    // entry end. Shifting by WIDTH (LANES == WIDTH) yields zero, so a
    // single-beat frame is simply the beat itself.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic [LANES-1:0] beat);
        logic [WIDTH-1:0] ext;
        ext            = '0;
        ext[LANES-1:0] = beat;
        if (MSB_FIRST != 0) begin
            return (cur << LANES) | ext;
        end
        return (cur >> LANES) | (ext << (WIDTH - LANES));
    endfunction

    // Handshake decode; s_ready depends combinationally on p_ready so a
    // waiting completion is accepted in the very cycle the consumer frees it.
    always_comb begin
        last_beat  = (beat_cnt == LAST_CNT);
        s_ready    = !clr_n || (!flush && !(last_beat && p_valid && !p_ready));
        accept     = s_valid && s_ready;
        consume    = p_valid && p_ready;
        sr_shifted = shift_in(sr, s_in);
    end

    // Frame assembly: shift register and beat counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sr       <= '0;
            beat_cnt <= '0;
        end else if (flush) begin
            sr       <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            sr <= sr_shifted;
            if (last_beat) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: a completion loads a new word (even when the old one is
    // consumed in the same cycle, so there is no bubble); a plain consume
    // just clears the valid flag and leaves the data in place.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            p_out   <= '0;
            p_valid <= 1'b0;
        end else if (flush) begin
            p_out   <= '0;
            p_valid <= 1'b0;
        end else if (accept && last_beat) begin
            p_out   <= sr_shifted;
            p_valid <= 1'b1;
        end else if (consume) begin
            p_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: three instances (16/1/LSB-first, 16/4/MSB-first,
// 16/4/LSB-first) against a beat-list reference model that assembles words
// arithmetically from the recorded beats.
module tb_shift_deserializer;

    logic       clk;
    logic       clr_n;
    logic       sv [2];
    logic [3:0] si [2];
    logic       pr [2];
    logic       fl [2];

    logic        srdy0, srdy1, srdy2;
    logic        pv0, pv1, pv2;
    logic [15:0] po0, po1, po2;
    logic [3:0]  bc0;
    logic [1:0]  bc1, bc2;

    shift_deserializer #(.WIDTH(16), .LANES(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .flush(fl[0]), .s_valid(sv[0]), .s_in(si[0][0]),
        .s_ready(srdy0), .p_out(po0), .p_valid(pv0), .p_ready(pr[0]), .beat_cnt(bc0));

    shift_deserializer #(.WIDTH(16), .LANES(4), .MSB_FIRST(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .flush(fl[1]), .s_valid(sv[1]), .s_in(si[1]),
        .s_ready(srdy1), .p_out(po1), .p_valid(pv1), .p_ready(pr[1]), .beat_cnt(bc1));

    shift_deserializer #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) dut2 (
        .clk(clk), .clr_n(clr_n), .flush(fl[1]), .s_valid(sv[1]), .s_in(si[1]),
        .s_ready(srdy2), .p_out(po2), .p_valid(pv2), .p_ready(pr[1]), .beat_cnt(bc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    int          lanes [3] = '{1, 4, 4};
    int          msbf  [3] = '{0, 1, 0};
    int          mcnt  [3];
    bit          mpv   [3];
    logic [15:0] mpo   [3];
    int          mbeat [3][16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int grp(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int nbeats(input int k);
        return 16 / lanes[k];
    endfunction

    function automatic logic [15:0] assemble(input int k);
        int w = 0;
        for (int i = 0; i < nbeats(k); i++) begin
            if (msbf[k] != 0) w = w | (mbeat[k][i] << (lanes[k] * (nbeats(k) - 1 - i)));
            else              w = w | (mbeat[k][i] << (lanes[k] * i));
        end
        return w[15:0];
    endfunction

    function automatic bit exp_rdy(input int k);
        int g = grp(k);
        return !fl[g] && !((mcnt[k] == nbeats(k) - 1) && mpv[k] && !pr[g]);
    endfunction

    function automatic logic get_srdy(input int k);
        return (k == 0) ? srdy0 : (k == 1) ? srdy1 : srdy2;
    endfunction
    function automatic logic get_pv(input int k);
        return (k == 0) ? pv0 : (k == 1) ? pv1 : pv2;
    endfunction
    function automatic logic [15:0] get_po(input int k);
        return (k == 0) ? po0 : (k == 1) ? po1 : po2;
    endfunction
    function automatic logic [3:0] get_bc(input int k);
        return (k == 0) ? bc0 : (k == 1) ? {2'b00, bc1} : {2'b00, bc2};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            mpv[k]  = 1'b0;
            mpo[k]  = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int g = grp(k);
            bit acc = sv[g] && exp_rdy(k);
            if (fl[g]) begin
                mcnt[k] = 0;
                mpv[k]  = 1'b0;
                mpo[k]  = '0;
            end else begin
                if (acc) begin
                    mbeat[k][mcnt[k]] = int'(si[g]) & ((1 << lanes[k]) - 1);
                    mcnt[k]++;
                end
                if (acc && mcnt[k] == nbeats(k)) begin
                    mpo[k]  = assemble(k);
                    mpv[k]  = 1'b1;
                    mcnt[k] = 0;
                end else if (mpv[k] && pr[g]) begin
                    mpv[k] = 1'b0;
                end
            end
        end
    endtask

    // One clock: check s_ready mid-cycle, advance model on the edge, check
    // registered outputs just after it. Called and returns at posedge+1.
    task automatic cyc();
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("s_ready%0d", k), 32'(get_srdy(k)), 32'(exp_rdy(k)));
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("p_valid%0d", k), 32'(get_pv(k)), 32'(mpv[k]));
            chk($sformatf("p_out%0d", k), 32'(get_po(k)), 32'(mpo[k]));
            chk($sformatf("beat_cnt%0d", k), 32'(get_bc(k)), 32'(mcnt[k]));
        end
    endtask

    task automatic beat1(input logic [3:0] d);
        sv[1] = 1'b1;
        si[1] = d;
        cyc();
    endtask

    task automatic idle_all();
        sv[0] = 1'b0;
        sv[1] = 1'b0;
    endtask

    logic [15:0] pat;

    initial begin
        clr_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            sv[g] = 1'b0; si[g] = '0; pr[g] = 1'b1; fl[g] = 1'b0;
        end
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_p_out%0d", k), 32'(get_po(k)), 32'h0);
            chk($sformatf("rst_p_valid%0d", k), 32'(get_pv(k)), 32'h0);
            chk($sformatf("rst_beat_cnt%0d", k), 32'(get_bc(k)), 32'h0);
            chk($sformatf("rst_s_ready%0d", k), 32'(get_srdy(k)), 32'h1);
        end
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // 16 single-bit beats, first beat ends in bit 0.
        pat = 16'h0F0D;
        for (int i = 0; i < 16; i++) begin
            sv[0] = 1'b1;
            si[0] = {3'b000, pat[i]};
            cyc();
        end
        chk("bits_word", 32'(po0), 32'h0F0D);
        chk("bits_valid", 32'(pv0), 32'h1);
        idle_all();
        cyc();
        chk("bits_valid_drop", 32'(pv0), 32'h0);

        // Nibble beats A,B,C,D in both shift orders.
        beat1(4'hA); beat1(4'hB); beat1(4'hC); beat1(4'hD);
        chk("msb_first_word", 32'(po1), 32'hABCD);
        chk("lsb_first_word", 32'(po2), 32'hDCBA);
        idle_all();
        cyc();

        // Consumer stalls while the second frame fills.
        pr[1] = 1'b0;
        beat1(4'h1); beat1(4'h2); beat1(4'h3); beat1(4'h4);
        beat1(4'h5); beat1(4'h6); beat1(4'h7);
        chk("stall_cnt", 32'(bc1), 32'h3);
        for (int i = 0; i < 3; i++) begin
            beat1(4'h8);
            chk("stall_s_ready", 32'(srdy1), 32'h0);
            chk("stall_hold", 32'(po1), 32'h1234);
        end
        pr[1] = 1'b1;
        beat1(4'h8);
        chk("stall_release_word", 32'(po1), 32'h5678);
        chk("stall_release_valid", 32'(pv1), 32'h1);
        idle_all();
        cyc();

        // Asynchronous reset mid-frame, then a clean frame.
        beat1(4'hE); beat1(4'hF);
        idle_all();
        #2;
        clr_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_p_out%0d", k), 32'(get_po(k)), 32'h0);
            chk($sformatf("arst_p_valid%0d", k), 32'(get_pv(k)), 32'h0);
            chk($sformatf("arst_beat_cnt%0d", k), 32'(get_bc(k)), 32'h0);
            chk($sformatf("arst_s_ready%0d", k), 32'(get_srdy(k)), 32'h1);
        end
        model_reset();
        #1;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        beat1(4'h9); beat1(4'hA); beat1(4'hB); beat1(4'hC);
        chk("post_rst_msb", 32'(po1), 32'h9ABC);
        chk("post_rst_lsb", 32'(po2), 32'hCBA9);

        // Flush coinciding with the completing beat: no word emerges.
        beat1(4'h1); beat1(4'h2); beat1(4'h3);
        fl[1] = 1'b1;
        beat1(4'h4);
        chk("flush_valid", 32'(pv1), 32'h0);
        chk("flush_p_out", 32'(po1), 32'h0);
        chk("flush_cnt", 32'(bc1), 32'h0);
        fl[1] = 1'b0;
        idle_all();
        cyc();

        // Back-to-back frames at full rate.
        for (int i = 0; i < 64; i++) begin
            for (int g = 0; g < 2; g++) begin
                sv[g] = 1'b1;
                si[g] = 4'($urandom);
                pr[g] = 1'b1;
            end
            cyc();
        end

        // Random traffic with consumer backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            for (int g = 0; g < 2; g++) begin
                sv[g] = ($urandom_range(0, 3) != 0);
                si[g] = 4'($urandom);
                pr[g] = ($urandom_range(0, 9) < 6);
                fl[g] = ($urandom_range(0, 49) == 0);
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
